// File: rtl/hamming_histogram_2b_pkg.sv
// hamming_histogram_2b_pkg: shared FSM encoding and histogram geometry
package hamming_histogram_2b_pkg;
   localparam int NUM_BINS = 4;
   localparam int SAMPLE_W = 2;
   localparam logic [1:0] ACCUM = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
endpackage

// File: rtl/hist_bin_counter.sv
// hist_bin_counter: saturating bin counter with synchronous clear and increment enable
module hist_bin_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             hit
);
   logic full;
   assign full = &count;
   // an increment at the ceiling is absorbed and reported instead of wrapping
   assign hit = inc & full;
   // count up on enable, hold at all-ones, zero on clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) count <= '0;
      else if (clear) count <= '0;
      else if (inc && !full) count <= count + 1'b1;
   end
endmodule

// File: rtl/hamming_histogram_2b.sv
// hamming_histogram_2b: four-bin histogram of 2-bit Hamming distances with handshaked drain
module hamming_histogram_2b #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             input_data_valid,
   input  logic [1:0]       input_data,
   input  logic             input_done,
   input  logic             clear,
   input  logic             rd_ready,
   output logic             output_data_valid,
   output logic [1:0]       output_bin,
   output logic [CNT_W-1:0] output_count,
   output logic             output_last,
   output logic             done,
   output logic             saturated,
   output logic             dropped
);
   import hamming_histogram_2b_pkg::*;
   logic [1:0] state;
   logic [1:0] idx;
   logic accept;
   logic [NUM_BINS-1:0] inc;
   logic [NUM_BINS-1:0] hit;
   logic [CNT_W-1:0] cnt [NUM_BINS];
   // samples only land while accumulating, and a clear cycle discards them
   assign accept = (state == ACCUM) && input_data_valid && !clear;
   for (genvar i = 0; i < NUM_BINS; i++) begin : g_bin
      assign inc[i] = accept && (input_data == SAMPLE_W'(i));
      hist_bin_counter #(.CNT_W(CNT_W)) u_bin (
         .clk   (clk),
         .rst   (rst),
         .clear (clear),
         .inc   (inc[i]),
         .count (cnt[i]),
         .hit   (hit[i])
      );
   end
   // control FSM: accumulate, drain one bin per accepted transfer, then park until clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ACCUM;
         idx       <= '0;
         saturated <= 1'b0;
         dropped   <= 1'b0;
      end else if (clear) begin
         state     <= ACCUM;
         idx       <= '0;
         saturated <= 1'b0;
         dropped   <= 1'b0;
      end else begin
         if (|hit) saturated <= 1'b1;
         if (input_data_valid && state != ACCUM) dropped <= 1'b1;
         if (state == ACCUM && input_done) begin
            state <= DRAIN;
            idx   <= '0;
         end else if (state == DRAIN && rd_ready) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) state <= DONE;
         end
      end
   end
   assign output_data_valid = (state == DRAIN);
   assign output_bin        = idx;
   assign output_count      = output_data_valid ? cnt[idx] : '0;
   assign output_last       = output_data_valid && (idx == 2'd3);
   assign done              = (state == DONE);
endmodule

// File: tb/tb_hamming_histogram_2b.sv
// tb_hamming_histogram_2b: directed scoreboard bench for the histogram (wide and narrow counters)
module tb_hamming_histogram_2b;
   typedef struct {
      logic [31:0] bin;
      logic [31:0] count;
      logic [31:0] last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   logic input_data_valid = 1'b0;
   logic [1:0] input_data = 2'd0;
   logic input_done = 1'b0;
   logic clear = 1'b0;
   logic rd_ready = 1'b0;
   logic sel = 1'b0;

   logic a_valid, a_last, a_done, a_sat, a_drop;
   logic [1:0] a_bin;
   logic [15:0] a_count;
   logic b_valid, b_last, b_done, b_sat, b_drop;
   logic [1:0] b_bin;
   logic [2:0] b_count;

   int checks = 0;
   int failures = 0;
   int model [4];
   exp_t q [$];

   always #5 clk = ~clk;

   hamming_histogram_2b #(.CNT_W(16)) dut_a (
      .clk(clk), .rst(rst_a), .input_data_valid(input_data_valid), .input_data(input_data),
      .input_done(input_done), .clear(clear), .rd_ready(rd_ready),
      .output_data_valid(a_valid), .output_bin(a_bin), .output_count(a_count),
      .output_last(a_last), .done(a_done), .saturated(a_sat), .dropped(a_drop)
   );

   hamming_histogram_2b #(.CNT_W(3)) dut_b (
      .clk(clk), .rst(rst_b), .input_data_valid(input_data_valid), .input_data(input_data),
      .input_done(input_done), .clear(clear), .rd_ready(rd_ready),
      .output_data_valid(b_valid), .output_bin(b_bin), .output_count(b_count),
      .output_last(b_last), .done(b_done), .saturated(b_sat), .dropped(b_drop)
   );

   logic o_valid, o_last, o_done, o_sat, o_drop;
   logic [1:0] o_bin;
   logic [31:0] o_count;
   assign o_valid = sel ? b_valid : a_valid;
   assign o_last  = sel ? b_last  : a_last;
   assign o_done  = sel ? b_done  : a_done;
   assign o_sat   = sel ? b_sat   : a_sat;
   assign o_drop  = sel ? b_drop  : a_drop;
   assign o_bin   = sel ? b_bin   : a_bin;
   assign o_count = sel ? {29'd0, b_count} : {16'd0, a_count};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] d, input logic with_done);
      int mx;
      mx = sel ? 7 : 65535;
      input_data_valid = 1'b1;
      input_data = d;
      input_done = with_done;
      step();
      input_data_valid = 1'b0;
      input_done = 1'b0;
      if (model[d] < mx) model[d]++;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
      foreach (model[i]) model[i] = 0;
      chk("clear_valid", o_valid, 0);
      chk("clear_done", o_done, 0);
      chk("clear_sat", o_sat, 0);
      chk("clear_drop", o_drop, 0);
   endtask

   task automatic start_drain();
      input_done = 1'b1;
      step();
      input_done = 1'b0;
   endtask

   // toggle=0 keeps rd_ready high; toggle=1 repeats the 1,0,0,1 pattern
   task automatic drain(input string tag, input bit toggle);
      logic [3:0] pat;
      int cyc;
      exp_t e;
      pat = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         e.bin = i;
         e.count = model[i];
         e.last = (i == 3);
         q.push_back(e);
      end
      cyc = 0;
      while (q.size() > 0 && cyc < 40) begin
         rd_ready = toggle ? pat[3 - (cyc % 4)] : 1'b1;
         chk({tag, "_valid"}, o_valid, 1);
         chk({tag, "_bin"}, o_bin, q[0].bin);
         chk({tag, "_count"}, o_count, q[0].count);
         chk({tag, "_last"}, o_last, q[0].last);
         step();
         if (rd_ready) void'(q.pop_front());
         cyc++;
      end
      rd_ready = 1'b0;
      chk({tag, "_budget"}, q.size(), 0);
      q.delete();
      if (!toggle) chk({tag, "_cycles"}, cyc, 4);
      chk({tag, "_done"}, o_done, 1);
      chk({tag, "_idle"}, o_valid, 0);
   endtask

   initial begin
      foreach (model[i]) model[i] = 0;
      #12;
      chk("rst_valid", o_valid, 0);
      chk("rst_bin", o_bin, 0);
      chk("rst_count", o_count, 0);
      chk("rst_last", o_last, 0);
      chk("rst_done", o_done, 0);
      chk("rst_sat", o_sat, 0);
      chk("rst_drop", o_drop, 0);
      rst_a = 1'b1;
      step();

      // bit-counter table over 64 inputs gives 8,24,24,8
      for (int v = 0; v < 64; v++) begin
         logic [5:0] vv;
         vv = v[5:0];
         send(2'($countones(vv[2:0])), 1'b0);
      end
      chk("tbl_model1", model[1], 24);
      start_drain();
      drain("tbl", 1'b0);
      chk("tbl_sat", o_sat, 0);
      chk("tbl_drop", o_drop, 0);
      do_clear();

      // sample coinciding with input_done still counts; drain with stalls
      send(2'd2, 1'b0);
      send(2'd2, 1'b0);
      send(2'd2, 1'b1);
      chk("same_cycle_valid", o_valid, 1);
      drain("stall", 1'b1);

      // sample in DONE is dropped; held input_done does not restart
      input_done = 1'b1;
      send(2'd0, 1'b1);
      model[0]--;
      step();
      input_done = 1'b0;
      chk("done_drop", o_drop, 1);
      chk("done_hold", o_done, 1);
      chk("done_norestart", o_valid, 0);
      do_clear();
      start_drain();
      drain("zero", 1'b0);
      do_clear();

      // reset while bin 1 is presented
      send(2'd1, 1'b0);
      send(2'd1, 1'b0);
      start_drain();
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      chk("pre_rst_bin", o_bin, 1);
      chk("pre_rst_count", o_count, 2);
      rst_a = 1'b0;
      #1;
      chk("async_valid", o_valid, 0);
      chk("async_count", o_count, 0);
      step();
      rst_a = 1'b1;
      foreach (model[i]) model[i] = 0;
      step();
      step();
      chk("post_rst_valid", o_valid, 0);
      // sample on a clear cycle is discarded
      clear = 1'b1;
      input_data_valid = 1'b1;
      input_data = 2'd3;
      step();
      clear = 1'b0;
      input_data_valid = 1'b0;
      start_drain();
      drain("post_rst", 1'b0);

      // narrow counter saturation
      rst_a = 1'b0;
      sel = 1'b1;
      foreach (model[i]) model[i] = 0;
      step();
      rst_b = 1'b1;
      step();
      for (int k = 0; k < 9; k++) send(2'd1, 1'b0);
      chk("sat_flag", o_sat, 1);
      chk("sat_model", model[1], 7);
      start_drain();
      drain("sat", 1'b0);
      chk("sat_sticky", o_sat, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
